// File: rtl/enc4to2_queue.sv
// Sequential 4-to-2 request encoder: captures request lines into a pending set and
// issues one 2-bit index per grant on a valid/ready port. Define ENC4TO2_ROUND_ROBIN_EN for rotating priority.
module enc4to2_queue (
   input  logic       clk_i,
   input  logic       resetn_i,
   input  logic       en_i,
   input  logic [0:3] w_i,
   input  logic       ready_i,
   output logic [1:0] y_o,
   output logic       valid_o,
   output logic       z_o
);

   logic [0:3] pend_q, pend_d;
   logic [1:0] y_q, y_d;
   logic       valid_q, valid_d;
   logic       z_q, z_d;
   logic [0:3] cand;
   logic       loadable;
   logic       found;
   logic [1:0] sel;
`ifdef ENC4TO2_ROUND_ROBIN_EN
   logic [1:0] last_q, last_d;
   logic [1:0] idx;
`endif

   assign cand     = pend_q | (en_i ? w_i : 4'b0000);
   assign loadable = !valid_q || ready_i;

   // Choose the next index to issue from the candidate set
   always_comb begin
      found = 1'b0;
      sel   = 2'b00;
`ifdef ENC4TO2_ROUND_ROBIN_EN
      idx   = 2'b00;
      for (int k = 0; k < 4; k++) begin
         idx = last_q + 2'(k + 1);
         if (!found && cand[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
`else
      for (int i = 0; i < 4; i++) begin
         if (!found && cand[i]) begin
            found = 1'b1;
            sel   = 2'(i);
         end
      end
`endif
   end

   always_comb begin
      pend_d  = cand;
      valid_d = valid_q;
      y_d     = y_q;
`ifdef ENC4TO2_ROUND_ROBIN_EN
      last_d  = last_q;
`endif
      if (loadable) begin
         if (found) begin
            y_d          = sel;
            valid_d      = 1'b1;
            pend_d[sel]  = 1'b0;
`ifdef ENC4TO2_ROUND_ROBIN_EN
            last_d       = sel;
`endif
         end else begin
            valid_d = 1'b0;
         end
      end
      z_d = valid_d | (|pend_d);
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         pend_q  <= 4'b0000;
         y_q     <= 2'b00;
         valid_q <= 1'b0;
         z_q     <= 1'b0;
`ifdef ENC4TO2_ROUND_ROBIN_EN
         last_q  <= 2'b11;
`endif
      end else begin
         pend_q  <= pend_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         z_q     <= z_d;
`ifdef ENC4TO2_ROUND_ROBIN_EN
         last_q  <= last_d;
`endif
      end
   end

   assign y_o     = y_q;
   assign valid_o = valid_q;
   assign z_o     = z_q;

endmodule

// File: tb/tb_enc4to2_queue.sv
// Self-checking bench for enc4to2_queue: expected grant indices are queued when
// requests are driven and popped whenever the DUT hands over a grant.
module tb_enc4to2_queue;

   logic       clk;
   logic       resetn;
   logic       en;
   logic [0:3] w;
   logic       ready;
   logic [1:0] y;
   logic       valid;
   logic       z;

   int checks = 0;
   int errors = 0;
   logic [1:0] sb[$];

   enc4to2_queue dut (
      .clk_i    (clk),
      .resetn_i (resetn),
      .en_i     (en),
      .w_i      (w),
      .ready_i  (ready),
      .y_o      (y),
      .valid_o  (valid),
      .z_o      (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Drive inputs for one clock; any grant handed over at that edge is scoreboarded
   task automatic applyStimulus(input logic e, input logic [0:3] req, input logic rdy);
      logic       acc;
      logic [1:0] yv;
      logic [1:0] ex;
      en    = e;
      w     = req;
      ready = rdy;
      #1;
      acc = valid && ready && resetn;
      yv  = y;
      @(posedge clk);
      #1;
      if (acc) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_grant", {2'b00, yv}, 4'hf);
         end else begin
            ex = sb.pop_front();
            checkOutput("grant_index", {2'b00, yv}, {2'b00, ex});
         end
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((sb.size() != 0 || valid) && n < budget) begin
         applyStimulus(1'b0, 4'b0000, 1'b1);
         n++;
      end
      checkOutput("drain_timeout", {3'b000, (sb.size() != 0 || valid)}, 4'h0);
   endtask

   task automatic doReset();
      resetn = 1'b0;
      applyStimulus(1'b1, 4'b1111, 1'b1);
      sb.delete();
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0;
      en     = 1'b0;
      w      = 4'b0000;
      ready  = 1'b0;

      // Reset state
      doReset();
      checkOutput("reset_valid", {3'b000, valid}, 4'h0);
      checkOutput("reset_y", {2'b00, y}, 4'h0);
      checkOutput("reset_z", {3'b000, z}, 4'h0);

      // Single request, one cycle latency
      sb.push_back(2'd0);
      applyStimulus(1'b1, 4'b1000, 1'b1);
      checkOutput("single_valid", {3'b000, valid}, 4'h1);
      checkOutput("single_y", {2'b00, y}, 4'h0);
      checkOutput("single_z", {3'b000, z}, 4'h1);
      applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("single_valid_after", {3'b000, valid}, 4'h0);
      checkOutput("single_z_after", {3'b000, z}, 4'h0);

      // Four simultaneous requests drain in four consecutive grants
      doReset();
      for (int i = 0; i < 4; i++) sb.push_back(2'(i));
      applyStimulus(1'b1, 4'b1111, 1'b1);
      for (int i = 0; i < 4; i++) begin
         checkOutput("burst_valid", {3'b000, valid}, 4'h1);
         applyStimulus(1'b0, 4'b0000, 1'b1);
      end
      checkOutput("burst_done_valid", {3'b000, valid}, 4'h0);
      checkOutput("burst_done_z", {3'b000, z}, 4'h0);

      // Backpressure holds the slot stable
      doReset();
      sb.push_back(2'd1);
      sb.push_back(2'd2);
      applyStimulus(1'b1, 4'b0110, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid", {3'b000, valid}, 4'h1);
         checkOutput("bp_y", {2'b00, y}, 4'h1);
         checkOutput("bp_z", {3'b000, z}, 4'h1);
         applyStimulus(1'b0, 4'b0000, 1'b0);
      end
      applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("bp_second_y", {2'b00, y}, 4'h2);
      applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("bp_end_valid", {3'b000, valid}, 4'h0);
      drain(10);

      // Capture disabled
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 4'b1111, 1'b1);
         checkOutput("noen_valid", {3'b000, valid}, 4'h0);
         checkOutput("noen_z", {3'b000, z}, 4'h0);
      end

      // Priority after granting index 1
      doReset();
      sb.push_back(2'd1);
      applyStimulus(1'b1, 4'b0100, 1'b1);
      drain(10);
`ifdef ENC4TO2_ROUND_ROBIN_EN
      sb.push_back(2'd3);
      sb.push_back(2'd0);
`else
      sb.push_back(2'd0);
      sb.push_back(2'd3);
`endif
      applyStimulus(1'b1, 4'b1001, 1'b1);
      drain(10);

      // Reset mid-burst discards everything
      doReset();
      sb.push_back(2'd0);
      applyStimulus(1'b1, 4'b1111, 1'b0);
      checkOutput("mid_pre_valid", {3'b000, valid}, 4'h1);
      doReset();
      checkOutput("mid_valid", {3'b000, valid}, 4'h0);
      checkOutput("mid_y", {2'b00, y}, 4'h0);
      checkOutput("mid_z", {3'b000, z}, 4'h0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 4'b0000, 1'b1);
         checkOutput("mid_stale_valid", {3'b000, valid}, 4'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
